wb_rr_arbiter: RTL and testbench
================================

# wb_rr_arbiter

Round-robin Wishbone arbiter that shares one Wishbone slave port between NUM_MASTER requesting masters. Examples are the Ibex data and instruction ports, or a DMA engine next to the core, in front of a single-ported peripheral or RAM. A master keeps its grant for as long as it holds cyc, which gives locked multi-transfer cycles. An optional watchdog aborts transfers the slave never acknowledges. The block sits between the masters and the shared-bus/slave side of the SoC.

## Interface
- NUM_MASTER, 2, number of requesting masters, 2..8
- AW, 32, address width
- DW, 32, data width; SW = DW/8 select lanes
- TIMEOUT, 255, cycles a strobed transfer may wait for ack/err before abort; ≥2; used only with the watchdog
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- m_cyc_i / m_stb_i / m_we_i  in  NUM_MASTER each  per-master Wishbone controls
- m_adr_i  in  NUM_MASTER*AW  per-master address, master i at [i*AW +: AW]
- m_dat_i  in  NUM_MASTER*DW  per-master write data
- m_sel_i  in  NUM_MASTER*SW  per-master byte selects
- m_dat_o  out  DW  read data, broadcast to all masters
- m_ack_o / m_err_o  out  NUM_MASTER each  per-master ack/err
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave controls
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_sel_o  out  SW  slave byte selects
- s_dat_i  in  DW  slave read data
- s_ack_i, s_err_i  in  1 each  slave ack/err
- gnt_o  out  NUM_MASTER  one-hot current grant; 0 when idle
- busy_o  out  1  a grant is active

## Operation
- The FSM has two states, IDLE and OWN. The grant index gnt_q and the last-owner pointer last_q are registered.
- IDLE: at a clock edge with any m_cyc_i high, grant the first requester found scanning upward cyclically from last_q+1. Go to OWN and set last_q to that index.
- OWN: slave outputs come from master gnt_q. s_cyc_o = m_cyc_i[gnt_q] and s_stb_o = m_stb_i[gnt_q], both combinational. m_ack_o[gnt_q] = s_ack_i and m_err_o[gnt_q] = s_err_i. All other masters see ack/err 0.
- OWN, granted cyc low at an edge: re-arbitrate at that same edge, using the IDLE rule over the current requests. Go to OWN with the new index, or to IDLE if there are no requests. A 0-cycle gap between owners is allowed.
- Requests from non-granted masters never reach the slave. They wait with no ack.
- m_dat_o = s_dat_i at all times.
- When no grant is active, all s_* outputs, gnt_o and busy_o are 0.

## Timing
- Reset (async assert, sync release) gives: IDLE, gnt_q=0, last_q=NUM_MASTER-1 (master 0 wins the first tie), watchdog counter 0. All outputs are 0.
- Grant latency: a master raising cyc at cycle t reaches the slave in cycle t+1 if the arbiter is IDLE.
- Ack/err pass through combinationally. Arbitration adds zero cycles per transfer once the grant is held.
- A master released at edge e cannot win again at e while another master is requesting (round-robin fairness).
- Simultaneous release and new requests: the scan starts after the releasing master.
- Reset asserted mid-transfer drops s_cyc_o immediately. Any pending ack is not delivered.

## Configuration
- WB_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT+1) increments each OWN cycle that has s_stb_o=1 and s_ack_i=s_err_i=0. It clears on ack, on err, on stb low and on a grant change.
  - When the count reaches TIMEOUT, for exactly one cycle: m_err_o[gnt_q]=1, s_cyc_o=s_stb_o=0, and any s_ack_i is ignored. The counter then clears and the grant is kept.
- WB_ARB_TIMEOUT_EN undefined: there is no counter, and a transfer waits on the slave indefinitely.

## Structure
- Package wb_arb_pkg: the state enum typedef (IDLE, OWN), and helper function next_rr(req, last) returning the index and a valid bit.
- Sub-module wb_rr_picker is natural. It is a combinational rotating priority encoder with inputs req[NUM_MASTER] and last_q, and outputs an index and valid. The top module keeps the registers, the mux and the watchdog.

## Test plan
- Master 1 alone issues a read of 0x0000_0010; the slave acks in cycle 2 with 0xDEAD_BEEF -> gnt_o=2'b10 one cycle after cyc, and m_dat_o=0xDEAD_BEEF with m_ack_o=2'b10.
- Both masters raise cyc in the first cycle after reset -> master 0 is served first, master 1 is granted at the edge where master 0 drops cyc, with no idle cycle.
- Both masters request continuously with single transfers, 20 transfers total -> grants alternate 0,1,0,1,… and each master gets exactly 10.
- Master 0 holds cyc for 3 back-to-back writes while master 1 requests -> master 1 sees no ack and s_adr_o never shows master 1's address until master 0 releases.
- With WB_ARB_TIMEOUT_EN and TIMEOUT=8, the slave never acks -> m_err_o[gnt] pulses for 1 cycle exactly 8 stb cycles after the strobe, and s_cyc_o is 0 in that cycle.
- rst_i is pulsed while master 1 is mid-transfer -> all outputs are 0 at once, and the first grant after release goes to master 0 when both request.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and the round-robin helper for the Wishbone arbiter.
// Optional watchdog in wb_rr_arbiter is enabled by defining WB_ARB_TIMEOUT_EN.
package wb_arb_pkg;

    // Upper bound on requesters the helper is sized for.
    localparam int unsigned MaxMaster = 8;
    localparam int unsigned MaxIdxW   = 3;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StOwn  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic               valid;
        logic [MaxIdxW-1:0] idx;
    } rr_pick_t;

    // First set bit of req scanning upward cyclically from last+1 over num entries.
    // The previous owner is visited last, which gives round-robin fairness.
    function automatic rr_pick_t next_rr(input logic [MaxMaster-1:0] req,
                                         input logic [MaxIdxW-1:0]   last,
                                         input int unsigned          num);
        rr_pick_t    res;
        int unsigned cand;
        res = '0;
        for (int unsigned k = 1; k <= MaxMaster; k++) begin
            cand = (32'(last) + k) % num;
            if (k <= num && !res.valid && req[cand[MaxIdxW-1:0]]) begin
                res.valid = 1'b1;
                res.idx   = cand[MaxIdxW-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational rotating priority encoder: picks the next requester after last_i.
module wb_rr_picker
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTER = 2,
    parameter int unsigned IW         = 1
) (
    input  logic [NUM_MASTER-1:0] req_i,
    input  logic [IW-1:0]         last_i,
    output logic [IW-1:0]         idx_o,
    output logic                  valid_o
);

    logic [MaxMaster-1:0] req_ext;
    logic [MaxIdxW-1:0]   last_ext;
    rr_pick_t             pick;
    logic                 unused_idx_bits;

    // Widen to the helper's fixed size, scan, then narrow back to the local index width.
    always_comb begin
        req_ext                   = '0;
        req_ext[NUM_MASTER-1:0]   = req_i;
        last_ext                  = MaxIdxW'(last_i);
        pick                      = next_rr(req_ext, last_ext, NUM_MASTER);
        valid_o                   = pick.valid;
        idx_o                     = IW'(pick.idx);
        unused_idx_bits           = ^pick.idx;
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTER masters share one slave port.
// A master keeps the grant while it holds cyc (locked multi-transfer cycles).
// Define WB_ARB_TIMEOUT_EN to add a watchdog that errors out unacknowledged strobes
// after TIMEOUT waiting cycles.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTER = 2,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    // Master side
    input  logic [NUM_MASTER-1:0]          m_cyc_i,
    input  logic [NUM_MASTER-1:0]          m_stb_i,
    input  logic [NUM_MASTER-1:0]          m_we_i,
    input  logic [NUM_MASTER*AW-1:0]       m_adr_i,
    input  logic [NUM_MASTER*DW-1:0]       m_dat_i,
    input  logic [NUM_MASTER*(DW/8)-1:0]   m_sel_i,
    output logic [DW-1:0]                  m_dat_o,
    output logic [NUM_MASTER-1:0]          m_ack_o,
    output logic [NUM_MASTER-1:0]          m_err_o,
    // Slave side
    output logic                           s_cyc_o,
    output logic                           s_stb_o,
    output logic                           s_we_o,
    output logic [AW-1:0]                  s_adr_o,
    output logic [DW-1:0]                  s_dat_o,
    output logic [DW/8-1:0]                s_sel_o,
    input  logic [DW-1:0]                  s_dat_i,
    input  logic                           s_ack_i,
    input  logic                           s_err_i,
    // Status
    output logic [NUM_MASTER-1:0]          gnt_o,
    output logic                           busy_o
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned IW = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] last_q, last_d;

    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic          wd_hit;

    wb_rr_picker #(
        .NUM_MASTER (NUM_MASTER),
        .IW         (IW)
    ) u_picker (
        .req_i   (m_cyc_i),
        .last_i  (last_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // State register: grant index and last-owner pointer; master 0 wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            last_q  <= IW'(NUM_MASTER - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state: arbitrate when idle, or at the edge where the owner drops cyc.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StOwn;
                    gnt_d   = pick_idx;
                    last_d  = pick_idx;
                end
            end
            StOwn: begin
                // Owner has cyc low here, so it cannot be re-picked while others wait.
                if (!m_cyc_i[gnt_q]) begin
                    if (pick_valid) begin
                        gnt_d  = pick_idx;
                        last_d = pick_idx;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned    WdW     = $clog2(TIMEOUT + 1);
    localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT);

    logic [WdW-1:0] wd_q, wd_d;

    assign wd_hit = (state_q == StOwn) && (wd_q == WdLimit);

    // Watchdog next value: count waiting strobe cycles, clear on any response,
    // stb low, the abort cycle itself, or a grant change (owner dropping cyc).
    always_comb begin
        wd_d = '0;
        if (state_q == StOwn && m_cyc_i[gnt_q] && m_stb_i[gnt_q] && !wd_hit &&
            !s_ack_i && !s_err_i) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    // Output mux: route the granted master to the slave and its response back.
    always_comb begin
        m_dat_o = s_dat_i;
        m_ack_o = '0;
        m_err_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        gnt_o   = '0;
        busy_o  = 1'b0;
        if (state_q == StOwn) begin
            busy_o         = 1'b1;
            gnt_o[gnt_q]   = 1'b1;
            s_cyc_o        = m_cyc_i[gnt_q];
            s_stb_o        = m_stb_i[gnt_q];
            s_we_o         = m_we_i[gnt_q];
            s_adr_o        = m_adr_i[gnt_q*AW +: AW];
            s_dat_o        = m_dat_i[gnt_q*DW +: DW];
            s_sel_o        = m_sel_i[gnt_q*SW +: SW];
            m_ack_o[gnt_q] = s_ack_i;
            m_err_o[gnt_q] = s_err_i;
            // Abort cycle: detach the slave and report an error to the owner.
            if (wd_hit) begin
                s_cyc_o        = 1'b0;
                s_stb_o        = 1'b0;
                m_ack_o[gnt_q] = 1'b0;
                m_err_o[gnt_q] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter with two masters.
module tb_wb_rr_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*SW-1:0] m_sel;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack, m_err;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_o, s_dat_i;
    logic [SW-1:0]   s_sel;
    logic            s_ack, s_err;
    logic [N-1:0]    gnt;
    logic            busy;

    int total = 0;
    int bad   = 0;

    wb_rr_arbiter #(
        .NUM_MASTER (N),
        .AW         (AW),
        .DW         (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_we_i  (m_we),
        .m_adr_i (m_adr),
        .m_dat_i (m_dat),
        .m_sel_i (m_sel),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack),
        .m_err_o (m_err),
        .s_cyc_o (s_cyc),
        .s_stb_o (s_stb),
        .s_we_o  (s_we),
        .s_adr_o (s_adr),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack),
        .s_err_i (s_err),
        .gnt_o   (gnt),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Inputs change #1 after posedge; checks run #3 later, well away from both edges.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic [31:0] adr0;
        logic        ack;
        logic [31:0] sdat;
        logic [1:0]  e_gnt;
        logic        e_scyc;
        logic [31:0] e_adr;
        logic [1:0]  e_ack;
        logic        e_busy;
    } vec_t;

    vec_t vecs[13];

    // Reference model state: owner index (-1 idle), round-robin pointer, watchdog count.
    int mdl_owner;
    int mdl_last;
    int mdl_wd;

    function automatic int mdl_scan(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    initial begin
        int          acks[N];
        int          nxfer, prev, alt_err;
        logic [1:0]  hold_low, drop_next;
        logic [N-1:0] cur_cyc;
        int          stb_start, err_at;
        logic        err_scyc;

        rst     = 1'b1;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = 2'b01;
        m_adr   = {32'h0000_0010, 32'h0000_0100};
        m_dat   = {32'h1111_1111, 32'h2222_2222};
        m_sel   = 8'hFF;
        s_dat_i = '0;
        s_ack   = 1'b0;
        s_err   = 1'b0;

        // Reset holds everything at zero even with requests present.
        next_cycle();
        m_cyc = 2'b11;
        m_stb = 2'b11;
        #3;
        check("reset_gnt", gnt, 0);
        check("reset_busy", busy, 0);
        check("reset_scyc", s_cyc, 0);
        check("reset_sadr", s_adr, 0);
        check("reset_ack", m_ack, 0);
        next_cycle();
        m_cyc = '0;
        m_stb = '0;
        rst   = 1'b0;
        next_cycle();

        // Single read by master 1, two simultaneous requesters, locked writes by master 0.
        vecs[0]  = '{2'b00, 2'b00, 32'h100, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0,   2'b00, 1'b0};
        vecs[1]  = '{2'b10, 2'b10, 32'h100, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0,   2'b00, 1'b0};
        vecs[2]  = '{2'b10, 2'b10, 32'h100, 1'b0, 32'h0,         2'b10, 1'b1, 32'h10,  2'b00, 1'b1};
        vecs[3]  = '{2'b10, 2'b10, 32'h100, 1'b1, 32'hDEAD_BEEF, 2'b10, 1'b1, 32'h10,  2'b10, 1'b1};
        vecs[4]  = '{2'b00, 2'b00, 32'h100, 1'b0, 32'h0,         2'b10, 1'b0, 32'h10,  2'b00, 1'b1};
        vecs[5]  = '{2'b11, 2'b11, 32'h100, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0,   2'b00, 1'b0};
        vecs[6]  = '{2'b11, 2'b11, 32'h100, 1'b1, 32'h0,         2'b01, 1'b1, 32'h100, 2'b01, 1'b1};
        vecs[7]  = '{2'b11, 2'b11, 32'h104, 1'b1, 32'h0,         2'b01, 1'b1, 32'h104, 2'b01, 1'b1};
        vecs[8]  = '{2'b11, 2'b11, 32'h108, 1'b1, 32'h0,         2'b01, 1'b1, 32'h108, 2'b01, 1'b1};
        vecs[9]  = '{2'b10, 2'b10, 32'h108, 1'b0, 32'h0,         2'b01, 1'b0, 32'h108, 2'b00, 1'b1};
        vecs[10] = '{2'b10, 2'b10, 32'h108, 1'b1, 32'hCAFE_0001, 2'b10, 1'b1, 32'h10,  2'b10, 1'b1};
        vecs[11] = '{2'b00, 2'b00, 32'h108, 1'b0, 32'h0,         2'b10, 1'b0, 32'h10,  2'b00, 1'b1};
        vecs[12] = '{2'b00, 2'b00, 32'h108, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0,   2'b00, 1'b0};

        for (int i = 0; i < 13; i++) begin
            m_cyc         = vecs[i].cyc;
            m_stb         = vecs[i].stb;
            m_adr[31:0]   = vecs[i].adr0;
            s_ack         = vecs[i].ack;
            s_dat_i       = vecs[i].sdat;
            #3;
            check($sformatf("vec%0d_gnt", i), gnt, vecs[i].e_gnt);
            check($sformatf("vec%0d_scyc", i), s_cyc, vecs[i].e_scyc);
            check($sformatf("vec%0d_sadr", i), s_adr, vecs[i].e_adr);
            check($sformatf("vec%0d_ack", i), m_ack, vecs[i].e_ack);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d_mdat", i), m_dat_o, vecs[i].sdat);
            next_cycle();
        end

        // Both masters issue single transfers back to back: grants must alternate.
        acks[0]  = 0;
        acks[1]  = 0;
        nxfer    = 0;
        prev     = -1;
        alt_err  = 0;
        hold_low = '0;
        for (int c = 0; c < 200 && nxfer < 20; c++) begin
            m_cyc   = ~hold_low;
            m_stb   = ~hold_low;
            s_ack   = 1'b1;
            s_dat_i = 32'(c);
            #3;
            drop_next = '0;
            for (int i = 0; i < N; i++) begin
                if (m_ack[i] && m_cyc[i]) begin
                    acks[i]++;
                    if (i == prev) alt_err++;
                    prev = i;
                    nxfer++;
                    drop_next[i] = 1'b1;
                end
            end
            hold_low = drop_next;
            next_cycle();
        end
        check("alt_total", nxfer, 20);
        check("alt_m0", acks[0], 10);
        check("alt_m1", acks[1], 10);
        check("alt_order", alt_err, 0);
        m_cyc = '0;
        m_stb = '0;
        s_ack = 1'b0;
        next_cycle();
        next_cycle();

`ifdef WB_ARB_TIMEOUT_EN
        // Slave never responds: one-cycle error exactly TO strobe cycles after the strobe.
        m_cyc     = 2'b01;
        m_stb     = 2'b01;
        stb_start = -1;
        err_at    = -1;
        err_scyc  = 1'b1;
        for (int c = 0; c < 40 && err_at < 0; c++) begin
            #3;
            if (stb_start < 0 && s_stb) stb_start = c;
            if (m_err[0]) begin
                err_at   = c;
                err_scyc = s_cyc;
            end
            next_cycle();
        end
        check("wd_offset", err_at - stb_start, TO);
        check("wd_scyc", err_scyc, 0);
        #3;
        check("wd_err_1cyc", m_err, 0);
        check("wd_gnt_kept", gnt, 2'b01);
        check("wd_scyc_back", s_cyc, 1);
        next_cycle();
        m_cyc = '0;
        m_stb = '0;
        next_cycle();
        next_cycle();
`endif

        // Reset in the middle of a master 1 transfer.
        m_cyc = 2'b10;
        m_stb = 2'b10;
        next_cycle();
        #2;
        check("rst_pre_gnt", gnt, 2'b10);
        s_ack = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_scyc", s_cyc, 0);
        check("rst_mid_gnt", gnt, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ack", m_ack, 0);
        next_cycle();
        s_ack = 1'b0;
        m_cyc = 2'b11;
        m_stb = 2'b11;
        rst   = 1'b0;
        next_cycle();
        #3;
        check("rst_first_gnt", gnt, 2'b01);
        m_cyc = '0;
        m_stb = '0;
        next_cycle();

        // Randomized traffic against the reference model, starting from a fresh reset.
        rst = 1'b1;
        next_cycle();
        rst       = 1'b0;
        mdl_owner = -1;
        mdl_last  = N - 1;
        mdl_wd    = 0;
        cur_cyc   = '0;
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] e_gnt, e_ack, e_err;
            logic         e_scyc, e_sstb, e_swe, hit;
            logic [AW-1:0] e_adr;
            logic [DW-1:0] e_dat;
            logic [SW-1:0] e_sel;
            int           nxt;

            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) cur_cyc[i] = ~cur_cyc[i];
            end
            m_cyc   = cur_cyc;
            m_stb   = N'($urandom);
            m_we    = N'($urandom);
            m_adr   = {$urandom, $urandom};
            m_dat   = {$urandom, $urandom};
            m_sel   = (N*SW)'($urandom);
            s_dat_i = $urandom;
            s_ack   = ($urandom_range(3) == 0);
            s_err   = ($urandom_range(7) == 0);
            #3;

            e_gnt  = '0;
            e_ack  = '0;
            e_err  = '0;
            e_scyc = 1'b0;
            e_sstb = 1'b0;
            e_swe  = 1'b0;
            e_adr  = '0;
            e_dat  = '0;
            e_sel  = '0;
            hit    = 1'b0;
            if (mdl_owner >= 0) begin
                e_gnt[mdl_owner] = 1'b1;
                e_scyc           = m_cyc[mdl_owner];
                e_sstb           = m_stb[mdl_owner];
                e_swe            = m_we[mdl_owner];
                e_adr            = m_adr[mdl_owner*AW +: AW];
                e_dat            = m_dat[mdl_owner*DW +: DW];
                e_sel            = m_sel[mdl_owner*SW +: SW];
                e_ack[mdl_owner] = s_ack;
                e_err[mdl_owner] = s_err;
`ifdef WB_ARB_TIMEOUT_EN
                hit = (mdl_wd == TO);
`endif
                if (hit) begin
                    e_scyc           = 1'b0;
                    e_sstb           = 1'b0;
                    e_ack[mdl_owner] = 1'b0;
                    e_err[mdl_owner] = 1'b1;
                end
            end
            check("rnd_gnt", gnt, e_gnt);
            check("rnd_busy", busy, (mdl_owner >= 0));
            check("rnd_scyc", s_cyc, e_scyc);
            check("rnd_sstb", s_stb, e_sstb);
            check("rnd_swe", s_we, e_swe);
            check("rnd_sadr", s_adr, e_adr);
            check("rnd_sdat", s_dat_o, e_dat);
            check("rnd_ssel", s_sel, e_sel);
            check("rnd_ack", m_ack, e_ack);
            check("rnd_err", m_err, e_err);
            check("rnd_mdat", m_dat_o, s_dat_i);

            // Advance the model across the coming edge.
            nxt = mdl_owner;
            if (mdl_owner < 0 || !m_cyc[mdl_owner]) begin
                nxt = mdl_scan(m_cyc, mdl_last);
                if (nxt >= 0) mdl_last = nxt;
            end
            if (nxt != mdl_owner || nxt < 0) begin
                mdl_wd = 0;
            end else if (m_stb[mdl_owner] && !hit && !s_ack && !s_err) begin
                mdl_wd++;
            end else begin
                mdl_wd = 0;
            end
            mdl_owner = nxt;
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
